// File: rtl/shift_unit_pipe.sv
// shift_unit_pipe: pipelined barrel shifter (SLL/SRL/SRA/ROR), one register per log2 shift stage
module shift_unit_pipe #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int TAG_W   = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag
);
  logic [WIDTH-1:0]   data_q  [SHAMT_W];
  logic [WIDTH-1:0]   data_d  [SHAMT_W];
  logic [SHAMT_W-1:0] shamt_q [SHAMT_W];
  logic [1:0]         op_q    [SHAMT_W];
  logic [TAG_W-1:0]   tag_q   [SHAMT_W];
  logic               sign_q  [SHAMT_W];
  logic [SHAMT_W-1:0] valid_q;
  logic [WIDTH-1:0]   src_data  [SHAMT_W];
  logic [SHAMT_W-1:0] src_shamt [SHAMT_W];
  logic [1:0]         src_op    [SHAMT_W];
  logic [TAG_W-1:0]   src_tag   [SHAMT_W];
  logic               src_sign  [SHAMT_W];
  logic [SHAMT_W-1:0] src_valid;
  logic               advance;

  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance && !flush;
  assign out_valid = valid_q[SHAMT_W-1];
  assign out_data  = data_q[SHAMT_W-1];
  assign out_tag   = tag_q[SHAMT_W-1];

  // src_*[s] is what stage s consumes: the request port for stage 0, the previous stage otherwise
  always_comb begin
    src_data[0]  = in_data;
    src_shamt[0] = in_shamt;
    src_op[0]    = in_op;
    src_tag[0]   = in_tag;
    src_sign[0]  = in_data[WIDTH-1];
    src_valid[0] = in_valid && in_ready;
    for (int s = 1; s < SHAMT_W; s++) begin
      src_data[s]  = data_q[s-1];
      src_shamt[s] = shamt_q[s-1];
      src_op[s]    = op_q[s-1];
      src_tag[s]   = tag_q[s-1];
      src_sign[s]  = sign_q[s-1];
      src_valid[s] = valid_q[s-1];
    end
  end

  // SRA fills from the sign captured at accept, not from the partially shifted word
  for (genvar g = 0; g < SHAMT_W; g++) begin : g_stage
    localparam int K = 1 << g;
    assign data_d[g] = !src_shamt[g][g] ? src_data[g] :
                       src_op[g] == 2'b00 ? src_data[g] << K :
                       src_op[g] == 2'b11 ? (src_data[g] >> K) | (src_data[g] << (WIDTH - K)) :
                       (src_data[g] >> K) | ({WIDTH{src_op[g] == 2'b10 && src_sign[g]}} << (WIDTH - K));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      for (int s = 0; s < SHAMT_W; s++) begin
        data_q[s]  <= '0;
        shamt_q[s] <= '0;
        op_q[s]    <= '0;
        tag_q[s]   <= '0;
        sign_q[s]  <= 1'b0;
      end
    end else begin
      if (advance || flush) valid_q <= flush ? '0 : src_valid;
      if (advance) begin
        for (int s = 0; s < SHAMT_W; s++) begin
          data_q[s]  <= data_d[s];
          shamt_q[s] <= src_shamt[s];
          op_q[s]    <= src_op[s];
          tag_q[s]   <= src_tag[s];
          sign_q[s]  <= src_sign[s];
        end
      end
    end
  end
endmodule

// File: tb/tb_shift_unit_pipe.sv
// tb_shift_unit_pipe: directed vector table, scoreboarded random stream, stall/flush/reset sequences
module tb_shift_unit_pipe;
  localparam int W = 32, SW = 5, TW = 5;

  logic clk = 0, rst = 1, flush = 0, in_valid = 0, rdy = 1, rnd_rdy = 0;
  logic [W-1:0] in_data = '0;
  logic [SW-1:0] in_shamt = '0;
  logic [1:0] in_op = '0;
  logic [TW-1:0] in_tag = '0;
  logic in_ready, out_valid;
  logic [W-1:0] out_data;
  logic [TW-1:0] out_tag;

  logic b_flush = 0, b_valid = 0, b_rdy = 1, b_in_ready, b_out_valid;
  logic [7:0] b_data = '0, b_out;
  logic [2:0] b_shamt = '0;
  logic [1:0] b_op = '0;
  logic [TW-1:0] b_tag = '0, b_out_tag;

  always #5 clk = ~clk;

  shift_unit_pipe #(.WIDTH(W), .SHAMT_W(SW), .TAG_W(TW)) dut (
    .clock(clk), .reset(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(rdy), .out_data(out_data), .out_tag(out_tag));

  shift_unit_pipe #(.WIDTH(8), .SHAMT_W(3), .TAG_W(TW)) dut8 (
    .clock(clk), .reset(rst), .flush(b_flush), .in_valid(b_valid), .in_ready(b_in_ready),
    .in_data(b_data), .in_shamt(b_shamt), .in_op(b_op), .in_tag(b_tag),
    .out_valid(b_out_valid), .out_ready(b_rdy), .out_data(b_out), .out_tag(b_out_tag));

  int n_cmp = 0, n_bad = 0, cyc = 0, stalls = 0, pops = 0, first_pop = -1, last_pop = -1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Reference: plain shift operators, signed >>>, and rotate as a window into {d,d}
  function automatic logic [W-1:0] ref_fn(input logic [W-1:0] d, input int sh, input logic [1:0] op);
    logic [2*W-1:0] dd;
    dd = {d, d};
    case (op)
      2'b00:   return d << sh;
      2'b01:   return d >> sh;
      2'b10:   return W'($signed(d) >>> sh);
      default: return dd[sh +: W];
    endcase
  endfunction

  typedef struct {logic [W-1:0] d; logic [TW-1:0] t; int acc; int st;} exp_t;
  exp_t q[$];

  always @(posedge clk) cyc++;

  always @(posedge clk) if (rnd_rdy) begin
    #1 rdy = $urandom_range(0, 3) != 0;
  end

  // Scoreboard: latency is SW plus every whole-pipe stall cycle seen while the item was in flight
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst) q.delete();
    else begin
      if (out_valid && rdy) begin
        if (q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_out: got tag %0h data %0h, required no output", out_tag, out_data);
        end else begin
          e = q.pop_front();
          chk("out_data", out_data, e.d);
          chk("out_tag", out_tag, e.t);
          chk("latency", cyc - e.acc, SW + stalls - e.st);
          pops++;
          if (first_pop < 0) first_pop = cyc;
          last_pop = cyc;
        end
      end
      if (flush) q.delete();
      else if (in_valid && in_ready) q.push_back('{ref_fn(in_data, in_shamt, in_op), in_tag, cyc, stalls});
      if (out_valid && !rdy) stalls++;
    end
  end

  task automatic send(input logic [W-1:0] d, input logic [SW-1:0] sh, input logic [1:0] op,
                      input logic [TW-1:0] t, output int acc_c);
    int k;
    logic acc;
    k = 0;
    in_data = d; in_shamt = sh; in_op = op; in_tag = t; in_valid = 1;
    do begin
      @(negedge clk); acc = in_ready; acc_c = cyc;
      @(posedge clk); #1; k++;
    end while (!acc && k < 200);
    in_valid = 0;
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic send_rnd();
    int a;
    send($urandom, SW'($urandom), 2'($urandom), TW'($urandom), a);
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (q.size() != 0 && k < 300) begin @(posedge clk); #1; k++; end
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
  endtask

  typedef struct {logic [W-1:0] d; logic [SW-1:0] sh; logic [1:0] op; logic [W-1:0] e;} vec_t;
  vec_t tv[10];

  typedef struct {logic [7:0] d; logic [2:0] sh; logic [1:0] op; logic [7:0] e;} vec8_t;
  vec8_t tv8[3];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a, k;
    logic [W-1:0] od;
    logic [TW-1:0] ot;
    tv[0] = '{32'h80000000, 5'd31, 2'b10, 32'hFFFFFFFF};
    tv[1] = '{32'h7FFFFFFF, 5'd31, 2'b10, 32'h00000000};
    tv[2] = '{32'h80000000, 5'd31, 2'b01, 32'h00000001};
    tv[3] = '{32'h00000001, 5'd31, 2'b00, 32'h80000000};
    tv[4] = '{32'h00000001, 5'd1,  2'b11, 32'h80000000};
    tv[5] = '{32'h12345678, 5'd16, 2'b11, 32'h56781234};
    tv[6] = '{32'hA5A5F00F, 5'd0,  2'b00, 32'hA5A5F00F};
    tv[7] = '{32'hA5A5F00F, 5'd0,  2'b01, 32'hA5A5F00F};
    tv[8] = '{32'hA5A5F00F, 5'd0,  2'b10, 32'hA5A5F00F};
    tv[9] = '{32'hA5A5F00F, 5'd0,  2'b11, 32'hA5A5F00F};
    tv8[0] = '{8'h80, 3'd7, 2'b10, 8'hFF};
    tv8[1] = '{8'h01, 3'd1, 2'b11, 8'h80};
    tv8[2] = '{8'h81, 3'd1, 2'b00, 8'h02};

    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst8_out_valid", b_out_valid, 0);
    chk("rst8_out_data", b_out, 0);

    foreach (tv[i]) begin
      send(tv[i].d, tv[i].sh, tv[i].op, TW'(i + 1), a);
      k = 0;
      do begin @(negedge clk); k++; end while (!out_valid && k < 20);
      chk("vec_latency", cyc - a, SW);
      chk("vec_data", out_data, tv[i].e);
      chk("vec_tag", out_tag, i + 1);
      @(posedge clk); #1;
    end

    pops = 0; first_pop = -1;
    repeat (20) send_rnd();
    wait_drain();
    chk("stream_count", pops, 20);
    chk("stream_contiguous", last_pop - first_pop, 19);

    rdy = 0; pops = 0;
    repeat (5) send_rnd();
    od = out_data; ot = out_tag;
    repeat (7) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_out_data", out_data, od);
      chk("stall_out_tag", out_tag, ot);
    end
    @(posedge clk); #1 rdy = 1;
    wait_drain();
    chk("stall_drain_count", pops, 5);

    repeat (3) send_rnd();
    in_data = $urandom; in_shamt = 5'd3; in_op = 2'b01; in_tag = 5'd9; in_valid = 1; flush = 1;
    @(negedge clk);
    chk("flush_in_ready", in_ready, 0);
    @(posedge clk); #1 flush = 0; in_valid = 0;
    repeat (5) begin @(negedge clk); chk("flush_out_valid", out_valid, 0); end
    @(posedge clk); #1;
    pops = 0;
    send(32'hF0000000, 5'd4, 2'b10, 5'd21, a);
    wait_drain();
    chk("post_flush_count", pops, 1);

    rdy = 0;
    repeat (5) send_rnd();
    rst = 1;
    @(posedge clk); #1 rst = 0;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_out_tag", out_tag, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    rdy = 1;
    repeat (8) begin @(negedge clk); chk("post_rst_out_valid", out_valid, 0); end

    foreach (tv8[i]) begin
      @(posedge clk); #1;
      b_data = tv8[i].d; b_shamt = tv8[i].sh; b_op = tv8[i].op; b_tag = TW'(i + 4); b_valid = 1;
      @(negedge clk);
      a = cyc;
      chk("w8_in_ready", b_in_ready, 1);
      @(posedge clk); #1 b_valid = 0;
      k = 0;
      do begin @(negedge clk); k++; end while (!b_out_valid && k < 10);
      chk("w8_latency", cyc - a, 3);
      chk("w8_data", b_out, tv8[i].e);
      chk("w8_tag", b_out_tag, i + 4);
    end
    @(posedge clk); #1;

    rnd_rdy = 1;
    repeat (60) begin
      send_rnd();
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
    rnd_rdy = 0;
    @(posedge clk); #2 rdy = 1;
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/shift_unit_pipe.md
Name: shift_unit_pipe

Overview:
- Parametrised, pipelined barrel shifter for the processor ALU path. Successor to the fixed 32-bit combinational arithmetic-right shifter.
- Supports four ops: SLL, SRL, SRA and ROR. Width is generic, with one register per log2 stage.
- Uses a valid/ready handshake, a pass-through tag for writeback bookkeeping, and a flush for branch squash.

Parameters:
- WIDTH, 32, data width; must be a power of 2, >= 2.
- SHAMT_W, 5, shift-amount width; must equal log2(WIDTH); also the number of pipeline stages.
- TAG_W, 5, width of the opaque tag carried alongside data (destination register index).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous squash of all in-flight operations.
- in_valid  input  1  request present.
- in_ready  output  1  unit can accept a request this cycle.
- in_data  input  WIDTH  operand.
- in_shamt  input  SHAMT_W  shift amount, 0..WIDTH-1.
- in_op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROR.
- in_tag  input  TAG_W  opaque tag.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- out_data  output  WIDTH  shifted result.
- out_tag  output  TAG_W  tag of the result.

Behaviour:
- Pipeline structure:
  - Stages s = 0..SHAMT_W-1. Stage s conditionally shifts by 2^s when its carried shamt bit s = 1; otherwise data passes unchanged.
  - Each stage registers data, shamt, op, tag and a valid bit.
  - Stage SHAMT_W-1 registers drive out_* directly.
- Fill rules per stage:
  - SLL: zeros fill the LSBs.
  - SRL: zeros fill the MSBs.
  - SRA: the MSBs are filled with the sign bit. The sign bit is the original in_data[WIDTH-1], captured at accept and carried down the pipe.
  - ROR: bits shifted out of the LSB re-enter at the MSB.
- Result equals the reference function of (in_data, in_shamt, in_op). in_shamt = 0 gives out_data = in_data for all ops.
- Latency and throughput:
  - Accept in cycle N gives out_valid in cycle N+SHAMT_W, absent stalls.
  - Throughput is 1 result/cycle.
- Handshake:
  - advance = !out_valid || out_ready.
  - in_ready = advance && !flush.
  - Accept occurs when in_valid && in_ready.
  - When advance = 1, every stage loads from the stage above. Stage 0 loads valid = (in_valid && in_ready).
  - When advance = 0, all stage registers hold and out_* stay stable.
  - A producer must hold in_* stable while in_valid && !in_ready.
- Output transfer:
  - Completes when out_valid && out_ready.
  - With a full pipe and out_ready = 1 every cycle, a new result is emitted each cycle with no bubbles.
- Flush:
  - Clears every stage valid bit at the next edge.
  - Takes priority over advance and over in_valid in the same cycle: nothing is accepted and out_valid = 0 in the following cycle.
  - Data/tag registers need not be cleared.
- Reset:
  - Clears all valid bits and all data/tag/shamt/op registers to 0.
  - out_valid = 0, out_data = 0, out_tag = 0, in_ready = 1 in the cycle after reset deasserts.
  - Reset mid-operation discards all in-flight results; no partial result is emitted.
  - Reset has priority over flush and over the handshake.
- Invalid stages:
  - Their data contents are don't-care.
  - out_data/out_tag are only defined while out_valid = 1.
  - Exception: after reset they are 0.
- Arithmetic: all widths are exact; no X propagation from unused stage registers into valid results.
- Structure: generate loops over WIDTH and SHAMT_W; no hard-coded 32.

Test Plan:
1. WIDTH=32, SRA 0x80000000 shamt 31 -> 0xFFFFFFFF. SRA 0x7FFFFFFF shamt 31 -> 0x00000000. SRL 0x80000000 shamt 31 -> 0x00000001. Each appears exactly 5 cycles after accept with the matching tag.
2. SLL 0x00000001 shamt 31 -> 0x80000000. ROR 0x00000001 shamt 1 -> 0x80000000. ROR 0x12345678 shamt 16 -> 0x56781234. All ops with shamt 0 return the input unchanged.
3. Back-to-back stream of 20 random ops with out_ready=1 -> 20 consecutive out_valid cycles, results matching the golden model, tags in order.
4. Backpressure: fill the pipe, then hold out_ready=0 for 7 cycles -> in_ready=0 and out_data/out_tag stable throughout. On release, remaining results drain in order with none lost or duplicated.
5. Flush with 3 ops in flight and in_valid=1 in the same cycle -> in_ready=0 that cycle, out_valid stays 0 for the next 5 cycles, and the next accepted op emerges correctly.
6. Assert reset for 1 cycle with a full, stalled pipe -> next cycle out_valid=0, out_data=0, out_tag=0, in_ready=1; no stale result ever appears. Repeat at WIDTH=8, SHAMT_W=3: SRA 0x80 by 7 -> 0xFF, 3-cycle latency.
